// File: rtl/clk_div_sched_if.sv
// Request/status bundle between a ratio requester and clk_div_sched.
// master = requester side, slave = controller side.
interface clk_div_sched_if #(
    parameter int SEL_W = 2
);
    logic             en;
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic             sw_done;
    logic [SEL_W-1:0] cur_sel;
    logic             busy;
    logic             clk_div;
    logic             period_strb;

    modport master (
        output en, req_valid, req_sel,
        input  req_ready, sw_done, cur_sel, busy, clk_div, period_strb
    );

    modport slave (
        input  en, req_valid, req_sel,
        output req_ready, sw_done, cur_sel, busy, clk_div, period_strb
    );
endinterface

// File: rtl/clk_div_sched.sv
// Power-of-two clock divider controller: one shared counter, glitch-free ratio/enable changes at period boundaries.
// Latency: clk_div registered (1 cycle); ratio switch completes at bnd(max(old,new)), at most 2^(m+1) cycles after accept.
// Backpressure: req_ready low while a switch is pending; requests arriving then wait until IDLE.
module clk_div_sched #(
    parameter int NSEL    = 4,
    parameter int SEL_W   = 2,
    parameter int RST_SEL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_sched_if.slave bus
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NSEL - 1);
    localparam logic [SEL_W:0]   NSEL_EXT  = (SEL_W + 1)'(NSEL);
    localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

    state_t           state, state_nxt;
    logic [NSEL-1:0]  cnt, cnt_nxt;
    logic [SEL_W-1:0] cur_sel, cur_sel_nxt;
    logic [SEL_W-1:0] pend_sel, pend_sel_nxt;
    logic [SEL_W-1:0] sel_max;
    logic             en_act, en_act_nxt;
    logic             sw_done, sw_done_nxt;
    logic             clk_div, clk_div_nxt;
    logic             period_strb, period_strb_nxt;
    logic             bnd_cur;

    // True when the low s+1 counter bits are all ones: last cycle of a ratio-s period.
    function automatic logic bnd_f(input logic [NSEL-1:0] c, input logic [SEL_W-1:0] s);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NSEL; i++) begin
            if (i <= int'(s)) r = r & c[i];
        end
        return r;
    endfunction

    always_comb begin
        state_nxt    = state;
        pend_sel_nxt = pend_sel;
        cur_sel_nxt  = cur_sel;
        sw_done_nxt  = 1'b0;
        cnt_nxt      = cnt + 1'b1;
        sel_max      = (cur_sel > pend_sel) ? cur_sel : pend_sel;
        bnd_cur      = bnd_f(cnt, cur_sel);

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    pend_sel_nxt = ({1'b0, bus.req_sel} >= NSEL_EXT) ? MAX_SEL : bus.req_sel;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                // Both old and new ratio bits are zero after bnd(max), so no runt phase.
                if (bnd_f(cnt, sel_max)) begin
                    cur_sel_nxt = pend_sel;
                    sw_done_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        en_act_nxt      = ((bus.en != en_act) && bnd_cur) ? bus.en : en_act;
        clk_div_nxt     = en_act_nxt & cnt_nxt[cur_sel_nxt];
        period_strb_nxt = en_act_nxt & bnd_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_sel     <= RST_SEL_V;
            pend_sel    <= '0;
            en_act      <= 1'b0;
            sw_done     <= 1'b0;
            clk_div     <= 1'b0;
            period_strb <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cur_sel     <= cur_sel_nxt;
            pend_sel    <= pend_sel_nxt;
            en_act      <= en_act_nxt;
            sw_done     <= sw_done_nxt;
            clk_div     <= clk_div_nxt;
            period_strb <= period_strb_nxt;
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.busy        = (state == PEND);
    assign bus.sw_done     = sw_done;
    assign bus.cur_sel     = cur_sel;
    assign bus.clk_div     = clk_div;
    assign bus.period_strb = period_strb;

endmodule
